// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store FSM with one memory transaction per access, lane alignment, extension and fault reporting
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        IS_STORE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] BASE,
  input  logic [31:0] OFFSET,
  input  logic [31:0] STORE_DATA,
  input  logic [4:0]  RD_IN,
  output logic        BUSY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_WSTRB,
  input  logic        MEM_READY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic [4:0]  RD,
  output logic [31:0] RD_DATA,
  output logic        WRITE_ENABLE,
  output logic        DONE,
  output logic        FAULT,
  output logic [1:0]  FAULT_CAUSE
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [31:0] ea, ea_q, wdata_q, load_val;
  logic [2:0] f3_q;
  logic [3:0] wstrb_q;
  logic [4:0] rd_q;
  logic st_q, illegal, misaligned, issue, issue_fault, timeout;
  logic [7:0] lb;
  logic [15:0] lh;
  assign ea = BASE + OFFSET;
  assign illegal = IS_STORE ? (FUNCT3 >= 3'd3) : (FUNCT3 == 3'd3 || FUNCT3 >= 3'd6);
  // FUNCT3[1:0] encodes access size for every legal code: 00 byte, 01 half, 10 word
  assign misaligned = (FUNCT3[1:0] == 2'd1 && ea[0]) || (FUNCT3[1:0] == 2'd2 && ea[1:0] != 2'd0);
  assign issue_fault = START && state == IDLE && (illegal || misaligned);
  assign issue = START && state == IDLE && !illegal && !misaligned;
  // last permitted waiting cycle; a handshake in this same cycle still wins
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign lb = MEM_RDATA[{ea_q[1:0], 3'b000} +: 8];
  assign lh = MEM_RDATA[{ea_q[1], 4'b0000} +: 16];
  assign load_val = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & lb[7]}}, lb} :
                    f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & lh[15]}}, lh} : MEM_RDATA;
  always_ff @(posedge CLK)
    state <= RESET ? IDLE : next;
  always_comb begin
    next = state == IDLE ? (issue ? REQ : IDLE) :
           state == REQ  ? (MEM_READY ? (st_q ? IDLE : WAIT_DATA) : (timeout ? IDLE : REQ)) :
           (MEM_RVALID || timeout) ? IDLE : WAIT_DATA;
  end
  always_comb begin
    BUSY = state != IDLE;
    MEM_REQ = state == REQ;
    MEM_WE = MEM_REQ & st_q;
    MEM_ADDR = MEM_REQ ? {ea_q[31:2], 2'b00} : 32'd0;
    MEM_WDATA = MEM_REQ ? wdata_q : 32'd0;
    MEM_WSTRB = MEM_REQ ? wstrb_q : 4'd0;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
      ea_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q <= '0;
      rd_q <= '0;
      st_q <= 1'b0;
      RD <= '0;
      RD_DATA <= '0;
      WRITE_ENABLE <= 1'b0;
      DONE <= 1'b0;
      FAULT <= 1'b0;
      FAULT_CAUSE <= '0;
    end else begin
      DONE <= 1'b0;
      FAULT <= 1'b0;
      WRITE_ENABLE <= 1'b0;
      cnt <= (state == next && state != IDLE) ? cnt + CW'(1) : '0;
      if (issue) begin
        ea_q <= ea;
        st_q <= IS_STORE;
        f3_q <= FUNCT3;
        rd_q <= RD_IN;
        wstrb_q <= !IS_STORE ? 4'b0000 :
                   FUNCT3[1:0] == 2'd0 ? 4'b0001 << ea[1:0] :
                   FUNCT3[1:0] == 2'd1 ? 4'b0011 << ea[1:0] : 4'b1111;
        wdata_q <= FUNCT3[1:0] == 2'd0 ? {4{STORE_DATA[7:0]}} :
                   FUNCT3[1:0] == 2'd1 ? {2{STORE_DATA[15:0]}} : STORE_DATA;
      end
      if (issue_fault) begin
        FAULT <= 1'b1;
        FAULT_CAUSE <= illegal ? 2'd2 : 2'd1;
      end
      if (state == REQ && MEM_READY && st_q)
        DONE <= 1'b1;
      if ((state == REQ && !MEM_READY && timeout) || (state == WAIT_DATA && !MEM_RVALID && timeout)) begin
        FAULT <= 1'b1;
        FAULT_CAUSE <= 2'd3;
      end
      if (state == WAIT_DATA && MEM_RVALID) begin
        DONE <= 1'b1;
        WRITE_ENABLE <= rd_q != 5'd0;
        RD <= rd_q;
        RD_DATA <= load_val;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand-written multi-cycle sequences for load_store_unit
module tb_load_store_unit;
  logic CLK = 1'b0, RESET, START, IS_STORE, MEM_READY, MEM_RVALID;
  logic [2:0] FUNCT3;
  logic [31:0] BASE, OFFSET, STORE_DATA, MEM_RDATA;
  logic [4:0] RD_IN;
  logic BUSY, MEM_REQ, MEM_WE, WRITE_ENABLE, DONE, FAULT;
  logic [31:0] MEM_ADDR, MEM_WDATA, RD_DATA;
  logic [3:0] MEM_WSTRB;
  logic [4:0] RD;
  logic [1:0] FAULT_CAUSE;
  int n_cmp = 0, n_err = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IS_STORE(IS_STORE), .FUNCT3(FUNCT3),
    .BASE(BASE), .OFFSET(OFFSET), .STORE_DATA(STORE_DATA), .RD_IN(RD_IN),
    .BUSY(BUSY), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_READY(MEM_READY),
    .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA), .RD(RD), .RD_DATA(RD_DATA),
    .WRITE_ENABLE(WRITE_ENABLE), .DONE(DONE), .FAULT(FAULT), .FAULT_CAUSE(FAULT_CAUSE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic st;
    logic [2:0] f3;
    logic [31:0] base, off, sdata;
    logic [4:0] rd;
    logic [31:0] rdata;
    logic [1:0] cause;
    logic [31:0] addr;
    logic [3:0] wstrb;
    logic [31:0] wdata, rdd;
    logic we;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] b, input logic [31:0] o,
                       input logic [31:0] sd, input logic [4:0] rd);
    START = 1'b1; IS_STORE = st; FUNCT3 = f3; BASE = b; OFFSET = o; STORE_DATA = sd; RD_IN = rd;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b, input logic [31:0] o,
                       input logic [31:0] sd, input logic [4:0] rd);
    @(negedge CLK);
    drive(st, f3, b, o, sd, rd);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.st, v.f3, v.base, v.off, v.sdata, v.rd);
    if (v.cause != 2'd0) begin
      chk("fault_pulse", FAULT, 1'b1);
      chk("fault_cause", FAULT_CAUSE, v.cause);
      chk("fault_busy", BUSY, 1'b0);
      chk("fault_memreq", MEM_REQ, 1'b0);
      @(negedge CLK);
      chk("fault_one_cycle", FAULT, 1'b0);
      chk("fault_memreq_after", MEM_REQ, 1'b0);
      return;
    end
    chk("req", MEM_REQ, 1'b1);
    chk("addr", MEM_ADDR, v.addr);
    chk("we", MEM_WE, v.st);
    chk("wstrb", MEM_WSTRB, v.wstrb);
    if (v.st) chk("wdata", MEM_WDATA, v.wdata);
    MEM_READY = 1'b1;
    @(negedge CLK);
    MEM_READY = 1'b0;
    if (v.st) begin
      chk("st_done", DONE, 1'b1);
      chk("st_nofault", FAULT, 1'b0);
      chk("st_nowe", WRITE_ENABLE, 1'b0);
      return;
    end
    chk("ld_busy", BUSY, 1'b1);
    chk("ld_early_done", DONE, 1'b0);
    MEM_RVALID = 1'b1; MEM_RDATA = v.rdata;
    @(negedge CLK);
    MEM_RVALID = 1'b0;
    chk("ld_done", DONE, 1'b1);
    chk("ld_we", WRITE_ENABLE, v.we);
    if (v.we) begin
      chk("ld_rd", RD, v.rd);
      chk("ld_rd_data", RD_DATA, v.rdd);
    end
    @(negedge CLK);
    chk("ld_done_one_cycle", DONE, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{0, 3'b010, 32'h1000, 32'd4, 32'h0, 5'd5, 32'hDEADBEEF, 2'd0, 32'h1004, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1};
    vecs[1]  = '{0, 3'b000, 32'h2000, 32'd3, 32'h0, 5'd6, 32'h80FF7F01, 2'd0, 32'h2000, 4'h0, 32'h0, 32'hFFFFFF80, 1'b1};
    vecs[2]  = '{0, 3'b100, 32'h2000, 32'd3, 32'h0, 5'd7, 32'h80FF7F01, 2'd0, 32'h2000, 4'h0, 32'h0, 32'h00000080, 1'b1};
    vecs[3]  = '{0, 3'b001, 32'h2000, 32'd2, 32'h0, 5'd8, 32'h80FF7F01, 2'd0, 32'h2000, 4'h0, 32'h0, 32'hFFFF80FF, 1'b1};
    vecs[4]  = '{0, 3'b101, 32'h2000, 32'd0, 32'h0, 5'd9, 32'h80FF7F01, 2'd0, 32'h2000, 4'h0, 32'h0, 32'h00007F01, 1'b1};
    vecs[5]  = '{0, 3'b000, 32'h2005, 32'hFFFFFFFC, 32'h0, 5'd10, 32'h80FF7F01, 2'd0, 32'h2000, 4'h0, 32'h0, 32'h0000007F, 1'b1};
    vecs[6]  = '{1, 3'b000, 32'h3000, 32'd1, 32'h12345678, 5'd0, 32'h0, 2'd0, 32'h3000, 4'b0010, 32'h78787878, 32'h0, 1'b0};
    vecs[7]  = '{1, 3'b001, 32'h3000, 32'd2, 32'h12345678, 5'd0, 32'h0, 2'd0, 32'h3000, 4'b1100, 32'h56785678, 32'h0, 1'b0};
    vecs[8]  = '{1, 3'b010, 32'h3000, 32'd4, 32'h12345678, 5'd0, 32'h0, 2'd0, 32'h3004, 4'b1111, 32'h12345678, 32'h0, 1'b0};
    vecs[9]  = '{0, 3'b010, 32'h1000, 32'd2, 32'h0, 5'd5, 32'h0, 2'd1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{0, 3'b011, 32'h1000, 32'd0, 32'h0, 5'd5, 32'h0, 2'd2, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
    vecs[11] = '{0, 3'b110, 32'h1000, 32'd1, 32'h0, 5'd5, 32'h0, 2'd2, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
    vecs[12] = '{1, 3'b001, 32'h3000, 32'd1, 32'h0, 5'd0, 32'h0, 2'd1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
    vecs[13] = '{0, 3'b010, 32'h1000, 32'd8, 32'h0, 5'd0, 32'h11223344, 2'd0, 32'h1008, 4'h0, 32'h0, 32'h0, 1'b0};
    RESET = 1'b1; START = 1'b0; IS_STORE = 1'b0; FUNCT3 = 3'd0; BASE = 32'd0; OFFSET = 32'd0;
    STORE_DATA = 32'd0; RD_IN = 5'd0; MEM_READY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_memreq", MEM_REQ, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_fault", FAULT, 1'b0);
    chk("rst_cause", FAULT_CAUSE, 2'd0);
    chk("rst_we", WRITE_ENABLE, 1'b0);
    chk("rst_rd_data", RD_DATA, 32'd0);
    chk("rst_wstrb", MEM_WSTRB, 4'd0);
    RESET = 1'b0;
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    issue(0, 3'b010, 32'h1000, 32'd0, 32'd0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", MEM_REQ, 1'b1);
      chk("to_no_early_fault", FAULT, 1'b0);
      @(negedge CLK);
    end
    chk("to_fault", FAULT, 1'b1);
    chk("to_cause", FAULT_CAUSE, 2'd3);
    chk("to_busy", BUSY, 1'b0);
    chk("to_memreq", MEM_REQ, 1'b0);
    chk("to_we", WRITE_ENABLE, 1'b0);
    issue(1, 3'b010, 32'h3004, 32'd0, 32'hA5A5A5A5, 5'd0);
    repeat (3) @(negedge CLK);
    chk("late_ready_req", MEM_REQ, 1'b1);
    MEM_READY = 1'b1;
    @(negedge CLK);
    MEM_READY = 1'b0;
    chk("late_ready_done", DONE, 1'b1);
    chk("late_ready_nofault", FAULT, 1'b0);
    issue(0, 3'b010, 32'h1000, 32'd0, 32'd0, 5'd3);
    MEM_READY = 1'b1;
    @(negedge CLK);
    MEM_READY = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rto_fault", FAULT, 1'b1);
    chk("rto_cause", FAULT_CAUSE, 2'd3);
    chk("rto_done", DONE, 1'b0);
    chk("rto_we", WRITE_ENABLE, 1'b0);
    issue(1, 3'b000, 32'h3000, 32'd1, 32'h12345678, 5'd0);
    MEM_READY = 1'b1;
    @(negedge CLK);
    MEM_READY = 1'b0;
    chk("b2b_first_done", DONE, 1'b1);
    drive(1, 3'b010, 32'h3008, 32'd0, 32'hCAFEBABE, 5'd0);
    @(negedge CLK);
    START = 1'b0;
    chk("b2b_req", MEM_REQ, 1'b1);
    chk("b2b_addr", MEM_ADDR, 32'h3008);
    chk("b2b_wstrb", MEM_WSTRB, 4'hF);
    MEM_READY = 1'b1;
    @(negedge CLK);
    MEM_READY = 1'b0;
    chk("b2b_second_done", DONE, 1'b1);
    issue(0, 3'b010, 32'h1000, 32'd0, 32'd0, 5'd9);
    MEM_READY = 1'b1;
    @(negedge CLK);
    MEM_READY = 1'b0;
    chk("abort_busy", BUSY, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_idle", BUSY, 1'b0);
    chk("abort_memreq", MEM_REQ, 1'b0);
    MEM_RVALID = 1'b1; MEM_RDATA = 32'hCAFEF00D;
    @(negedge CLK);
    MEM_RVALID = 1'b0;
    chk("abort_we", WRITE_ENABLE, 1'b0);
    chk("abort_done", DONE, 1'b0);
    chk("abort_fault", FAULT, 1'b0);
    chk("abort_rd", RD, 5'd0);
    chk("abort_rd_data", RD_DATA, 32'd0);
    chk("abort_cause", FAULT_CAUSE, 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle RV32I load/store unit between operand read and register writeback. Takes base (R1_DATA), sign-extended offset and store data (R2_DATA) from the register file side and runs one request/response transaction on a 32-bit word-addressed data memory port. It then drives RD/RD_DATA/WRITE_ENABLE directly into the register file write port with byte/halfword alignment and sign/zero extension. It reports misalignment, illegal encodings and memory timeouts instead of accessing memory.

## Interface
- TIMEOUT, 64: max cycles spent waiting for MEM_READY or MEM_RVALID before a timeout fault (≥1).
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  issue strobe; sampled only when BUSY=0.
- IS_STORE  in  1  1=store, 0=load.
- FUNCT3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW.
- BASE  in  32  base address.
- OFFSET  in  32  sign-extended immediate.
- STORE_DATA  in  32  store source value.
- RD_IN  in  5  load destination register.
- BUSY  out  1  high when the FSM is not in IDLE.
- MEM_REQ  out  1  request valid.
- MEM_WE  out  1  1=write.
- MEM_ADDR  out  32  word address: EA with bits [1:0] forced to 0.
- MEM_WDATA  out  32  lane-replicated write data.
- MEM_WSTRB  out  4  byte enables.
- MEM_READY  in  1  request accepted this cycle.
- MEM_RVALID  in  1  read data valid.
- MEM_RDATA  in  32  read data.
- RD  out  5  destination register to the register file.
- RD_DATA  out  32  extended load result.
- WRITE_ENABLE  out  1  one-cycle register-file write pulse.
- DONE  out  1  one-cycle completion pulse.
- FAULT  out  1  one-cycle fault pulse.
- FAULT_CAUSE  out  2  1 misaligned, 2 illegal FUNCT3, 3 timeout; holds last value.

## Operation
- States: IDLE, REQ, WAIT_DATA.
- IDLE, START=1:
  - EA = BASE+OFFSET, mod 2^32.
  - Illegal FUNCT3 (loads 011/110/111; stores ≥011) → fault cause 2.
  - Otherwise, misaligned (H with EA[0]≠0, W with EA[1:0]≠0) → fault cause 1.
  - Illegal encoding takes priority over misalignment.
  - On fault: no memory access, stay IDLE.
  - Else latch all request fields and RD_IN, go to REQ.
- REQ: MEM_REQ=1; MEM_WE/ADDR/WDATA/WSTRB stay stable until MEM_READY=1.
  - On MEM_READY: a store completes and returns to IDLE; a load goes to WAIT_DATA.
- WAIT_DATA: on MEM_RVALID, extract the byte at RDATA[8·EA[1:0]+:8] (byte) or RDATA[16·EA[1]+:16] (half).
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the full word.
  - Register the result into RD_DATA and return to IDLE.
- Store lanes:
  - SB: WSTRB=0001<<EA[1:0], WDATA = byte ×4.
  - SH: WSTRB=0011<<EA[1:0], WDATA = half ×2.
  - SW: WSTRB=1111.
- Loads drive WSTRB=0000, MEM_WE=0.
- RD_IN=0 load: the memory read is still performed and DONE still pulses; WRITE_ENABLE stays 0.
- Timeout: a cycle counter clears on entry to REQ and WAIT_DATA.
  - If the awaited handshake is not seen within TIMEOUT cycles, return to IDLE, drop MEM_REQ, fault cause 3, no write.
  - A handshake arriving in the TIMEOUT-th cycle wins over the timeout.
- START while BUSY=1 is ignored. MEM_RVALID outside WAIT_DATA is ignored. MEM_READY outside REQ is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- RESET mid-transaction: next edge returns to IDLE; MEM_REQ low the following cycle; no WRITE_ENABLE/DONE/FAULT for the aborted access.
- DONE, FAULT, WRITE_ENABLE are registered and assert in the first cycle back in IDLE, for exactly one cycle.
  - START is accepted in that same cycle (back-to-back issue).
- START accepted at edge n → MEM_REQ high from cycle n+1.
- Minimum store: READY in n+1 → DONE in n+2.
- Minimum load: READY in n+1, RVALID in n+2 → WRITE_ENABLE+DONE in n+3.
  - RVALID is not sampled in the MEM_READY cycle.
- Fault at START (edge n) → FAULT in cycle n+1; BUSY never rises.
- RD and RD_DATA hold their values after a write until the next load completes.

## Test plan
- LW, BASE=0x1000, OFFSET=4, RD_IN=5, READY immediate, RDATA=0xDEADBEEF → MEM_ADDR=0x1004, WRITE_ENABLE pulse 3 cycles after START, RD=5, RD_DATA=0xDEADBEEF.
- LB/LBU at EA=0x2003, RDATA=0x80FF7F01 → LB gives 0xFFFFFF80; LBU gives 0x00000080; LH at 0x2002 gives 0xFFFF80FF.
- SB at EA=0x3001, STORE_DATA=0x12345678 → WSTRB=0010, WDATA=0x78787878, MEM_ADDR=0x3000; SH at 0x3002 → WSTRB=1100, WDATA=0x56785678; DONE 2 cycles after START.
- LW at EA=0x1002 → FAULT next cycle, cause 1, MEM_REQ never high; FUNCT3=011 load → cause 2.
- TIMEOUT=4, MEM_READY held 0 → MEM_REQ high 4 cycles, then FAULT cause 3, BUSY low; READY in the 4th cycle → no fault.
- Load stalled in WAIT_DATA, RESET pulsed, then late RVALID → no WRITE_ENABLE, all outputs 0; LW with RD_IN=0 → DONE pulse, WRITE_ENABLE stays 0.
